// File: rtl/usb_rcv_seq.sv
// usb_rcv_seq: receive-side sequencer for the bit-serial USB receive FIFO.
// Writes de-stuffed payload bits into the FIFO, checks CRC16 and length,
// rolls back the trailing CRC on success and clears the FIFO on error.
module usb_rcv_seq #(
    parameter int unsigned MAX_BYTES = 64,
    parameter int unsigned CNT_WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 rst0_async,
    input  logic                 rst0_sync,
    input  logic                 rx_start,
    input  logic                 rx_is_setup,
    input  logic                 rx_bit_en,
    input  logic                 rx_bit,
    input  logic                 rx_eop,
    input  logic                 rx_err,
    input  logic                 fifo_full,
    output logic                 fifo_wr_en,
    output logic                 fifo_wr_data,
    output logic                 fifo_wr_minus16,
    output logic                 fifo_clr0,
    output logic                 busy,
    output logic                 done,
    output logic                 ok,
    output logic                 err_crc,
    output logic                 err_len,
    output logic                 err_ovf,
    output logic [CNT_WIDTH-1:0] byte_cnt
);

    // Payload plus the two CRC bytes; the bit counter saturates here.
    localparam int unsigned MaxBits = (MAX_BYTES + 2) * 8;
    localparam int unsigned BitW    = $clog2(MaxBits + 1);

    typedef enum logic [1:0] {StIdle, StRecv, StCheck, StAbort} state_e;

    state_e               state_q, state_d;
    logic [15:0]          crc_q, crc_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic                 setup_q, setup_d;
    logic                 ovf_q, ovf_d;
    logic                 wr_en_q, wr_en_d;
    logic                 wr_data_q, wr_data_d;
    logic                 minus16_q, minus16_d;
    logic                 clr0_q, clr0_d;
    logic                 done_q, done_d;
    logic                 ok_q, ok_d;
    logic                 err_crc_q, err_crc_d;
    logic                 err_len_q, err_len_d;
    logic                 err_ovf_q, err_ovf_d;
    logic [CNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;

    logic                 len_bad, crc_bad, at_limit;
    logic [BitW-1:0]      payload_bits;

    // Reflected CRC16 (poly 0x8005), one bit per call.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        return (c >> 1) ^ (fb ? 16'hA001 : 16'h0000);
    endfunction

    assign at_limit     = (bit_cnt_q == BitW'(MaxBits));
    assign len_bad      = (bit_cnt_q[2:0] != 3'd0) || (bit_cnt_q < BitW'(16)) ||
                          (setup_q && (bit_cnt_q != BitW'(80)));
    // Residual of a good packet in the reflected register is 0xB001.
    assign crc_bad      = (crc_q != 16'hB001);
    assign payload_bits = bit_cnt_q - BitW'(16);

    // State register.
    always_ff @(posedge clk or negedge rst0_async) begin
        if (!rst0_async) begin
            state_q <= StIdle;
        end else if (!rst0_sync) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (rx_start) state_d = StRecv;
            StRecv: begin
                if (rx_err) begin
                    state_d = StAbort;
                end else if (rx_eop) begin
                    state_d = StCheck;
                end
            end
            StCheck: state_d = (len_bad || crc_bad || ovf_q) ? StAbort : StIdle;
            StAbort: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        crc_d      = crc_q;
        bit_cnt_d  = bit_cnt_q;
        setup_d    = setup_q;
        ovf_d      = ovf_q;
        wr_en_d    = 1'b0;
        wr_data_d  = 1'b0;
        minus16_d  = 1'b0;
        clr0_d     = 1'b1;
        done_d     = 1'b0;
        ok_d       = ok_q;
        err_crc_d  = err_crc_q;
        err_len_d  = err_len_q;
        err_ovf_d  = err_ovf_q;
        byte_cnt_d = byte_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (rx_start) begin
                    crc_d      = 16'hFFFF;
                    bit_cnt_d  = '0;
                    setup_d    = rx_is_setup;
                    ovf_d      = 1'b0;
                    ok_d       = 1'b0;
                    err_crc_d  = 1'b0;
                    err_len_d  = 1'b0;
                    err_ovf_d  = 1'b0;
                    byte_cnt_d = '0;
                end
            end
            StRecv: begin
                if (rx_bit_en) begin
                    crc_d = crc_step(crc_q, rx_bit);
                    if (at_limit || fifo_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_data_d = rx_bit;
                    end
                    if (!at_limit) begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end
            end
            StCheck: begin
                err_len_d  = len_bad;
                err_crc_d  = crc_bad;
                err_ovf_d  = ovf_q;
                byte_cnt_d = (bit_cnt_q < BitW'(16)) ? '0 : CNT_WIDTH'(payload_bits >> 3);
                if (!(len_bad || crc_bad || ovf_q)) begin
                    minus16_d = 1'b1;
                    done_d    = 1'b1;
                    ok_d      = 1'b1;
                end
            end
            StAbort: begin
                clr0_d = 1'b0;
                done_d = 1'b1;
                ok_d   = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst0_async) begin
        if (!rst0_async) begin
            crc_q      <= 16'hFFFF;
            bit_cnt_q  <= '0;
            setup_q    <= 1'b0;
            ovf_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= 1'b0;
            minus16_q  <= 1'b0;
            clr0_q     <= 1'b1;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_crc_q  <= 1'b0;
            err_len_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
            byte_cnt_q <= '0;
        end else if (!rst0_sync) begin
            crc_q      <= 16'hFFFF;
            bit_cnt_q  <= '0;
            setup_q    <= 1'b0;
            ovf_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= 1'b0;
            minus16_q  <= 1'b0;
            clr0_q     <= 1'b1;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_crc_q  <= 1'b0;
            err_len_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
            byte_cnt_q <= '0;
        end else begin
            crc_q      <= crc_d;
            bit_cnt_q  <= bit_cnt_d;
            setup_q    <= setup_d;
            ovf_q      <= ovf_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            minus16_q  <= minus16_d;
            clr0_q     <= clr0_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            err_crc_q  <= err_crc_d;
            err_len_q  <= err_len_d;
            err_ovf_q  <= err_ovf_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign busy            = (state_q != StIdle);
    assign fifo_wr_en      = wr_en_q;
    assign fifo_wr_data    = wr_data_q;
    assign fifo_wr_minus16 = minus16_q;
    assign fifo_clr0       = clr0_q;
    assign done            = done_q;
    assign ok              = ok_q;
    assign err_crc         = err_crc_q;
    assign err_len         = err_len_q;
    assign err_ovf         = err_ovf_q;
    assign byte_cnt        = byte_cnt_q;

endmodule
